// File: rtl/regfile_wb_ctrl.sv
// Write-back initiator: merges single-cycle ALU results and queued long-latency results
// into the register file's single write port, and tracks registers awaiting long-latency writes.
module regfile_wb_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ll_valid,
   output logic        ll_ready,
   input  logic [4:0]  ll_rd,
   input  logic [31:0] ll_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   output logic [31:0] pending,
   output logic        wen,
   output logic [4:0]  wraddr,
   output logic [31:0] wrdata
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [4:0]    fifo_rd   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          alu_sel;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;
   logic          sel_wen;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data;
   logic [31:0]   pend_q;
   logic [31:0]   pend_d;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign ll_ready  = ~full;
   assign head_rd   = fifo_rd[rd_ptr];
   assign head_data = fifo_data[rd_ptr];

   // Results for x0 are handshaken but never stored.
   assign push    = ll_valid & ~full & (ll_rd != 5'd0);
   assign alu_sel = ~hold & alu_valid & (alu_rd != 5'd0);
   assign pop     = ~hold & ~alu_sel & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= ll_rd;
         fifo_data[wr_ptr] <= ll_data;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      sel_wen  = 1'b0;
      sel_rd   = 5'd0;
      sel_data = 32'd0;
      if (alu_sel) begin
         sel_wen  = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end else if (pop) begin
         sel_wen  = 1'b1;
         sel_rd   = head_rd;
         sel_data = head_data;
      end
   end

   // A stall freezes the write so the register file commits it once the stall lifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen    <= 1'b0;
         wraddr <= 5'd0;
         wrdata <= 32'd0;
      end else if (!hold) begin
         // NOTE: non-blocking here so every flop samples pre-edge values; blocking is for comb only.
         wen    <= sel_wen;
         wraddr <= sel_rd;
         wrdata <= sel_data;
      end
   end

   // Set is applied after clear, so a re-issue to the same register stays pending.
   always_comb begin
      pend_d = pend_q;
      if (pop) pend_d[head_rd] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) pend_d[iss_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   assign pending = pend_q;

endmodule
